// File: rtl/memarb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memarb_pkg
// Brief    : Shared encodings for the memory arbiter (states, requester slots).
// Revision : 1.0
// ============================================================================
package memarb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Bit positions inside every 3-bit grant / done vector
    localparam int REQ_WB = 0;
    localparam int REQ_D  = 1;
    localparam int REQ_I  = 2;

    localparam logic [31:0] BADDATA     = 32'hDEADBEEF;
    localparam logic [3:0]  FULL_BYTEEN = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/memarbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memarbiter_if
// Brief    : Requester and main-memory bus bundle seen by the memory arbiter.
// Revision : 1.0
// ============================================================================
interface memarbiter_if;

    logic        swc;
    logic        wben;
    logic [29:0] wbadr;
    logic [31:0] wbdata;
    logic [3:0]  wbbyteen;
    logic        den;
    logic [29:0] dadr;
    logic        ien;
    logic [29:0] iadr;
    logic        wbdone;
    logic        ddone;
    logic        idone;
    logic [31:0] rdata;
    logic [29:0] memadr;
    logic [31:0] memwdata;
    logic [3:0]  membyteen;
    logic        memrwb;
    logic        memen;
    logic [31:0] memrdata;
    logic        memdone;
    logic        err;

    // master: the arbiter itself, which masters the main-memory port
    modport master (
        input  swc, wben, wbadr, wbdata, wbbyteen, den, dadr, ien, iadr,
        input  memrdata, memdone,
        output wbdone, ddone, idone, rdata,
        output memadr, memwdata, membyteen, memrwb, memen, err
    );

    modport slave (
        output swc, wben, wbadr, wbdata, wbbyteen, den, dadr, ien, iadr,
        output memrdata, memdone,
        input  wbdone, ddone, idone, rdata,
        input  memadr, memwdata, membyteen, memrwb, memen, err
    );

endinterface
`default_nettype wire

// File: rtl/memarb_prio.sv
`default_nettype none
// ============================================================================
// Module   : memarb_prio
// Brief    : Combinational fixed-priority grant: wb first, then d/i by swc.
// Revision : 1.0
// ============================================================================
module memarb_prio
    import memarb_pkg::*;
(
    input  wire logic       wben,
    input  wire logic       den,
    input  wire logic       ien,
    input  wire logic       swc,
    output logic [2:0]      grant
);

    always_comb begin
        grant = 3'b000;
        if (wben) begin
            grant[REQ_WB] = 1'b1;
        end else if (swc) begin
            if (ien)
                grant[REQ_I] = 1'b1;
            else if (den)
                grant[REQ_D] = 1'b1;
        end else begin
            if (den)
                grant[REQ_D] = 1'b1;
            else if (ien)
                grant[REQ_I] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memarbiter.sv
`default_nettype none
// ============================================================================
// Module   : memarbiter
// Brief    : Single-port main-memory arbiter for write buffer, dcache, icache.
//            Optional BUSY watchdog enabled by defining MEMARB_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module memarbiter
    import memarb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     reset,
    memarbiter_if.master  bus
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  w_grant;
    logic [2:0]  r_grant;
    logic [2:0]  w_done;
    logic        w_req_any;
    logic        w_timeout;

    logic        r_memen;
    logic [29:0] r_memadr;
    logic [31:0] r_memwdata;
    logic [3:0]  r_membyteen;
    logic        r_memrwb;
    logic [31:0] r_rdata;

    memarb_prio u_prio (
        .wben  (bus.wben),
        .den   (bus.den),
        .ien   (bus.ien),
        .swc   (bus.swc),
        .grant (w_grant)
    );

    assign w_req_any = |w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_any) w_state_nxt = BUSY;
            BUSY:    if (bus.memdone || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_done = 3'b000;
        if (r_state == RESP)
            w_done = r_grant;
    end

    // Memory request is captured once at grant and held untouched through BUSY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant     <= 3'b000;
            r_memen     <= 1'b0;
            r_memadr    <= 30'd0;
            r_memwdata  <= 32'd0;
            r_membyteen <= 4'b0000;
            r_memrwb    <= 1'b1;
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_grant <= w_grant;
                        r_memen <= 1'b1;
                        if (w_grant[REQ_WB]) begin
                            r_memadr    <= bus.wbadr;
                            r_memwdata  <= bus.wbdata;
                            r_membyteen <= bus.wbbyteen;
                            r_memrwb    <= 1'b0;
                        end else begin
                            r_memadr    <= w_grant[REQ_D] ? bus.dadr : bus.iadr;
                            r_membyteen <= FULL_BYTEEN;
                            r_memrwb    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.memdone) begin
                        r_memen <= 1'b0;
                        if (r_memrwb)
                            r_rdata <= bus.memrdata;
                    end else if (w_timeout) begin
                        r_memen <= 1'b0;
                        r_rdata <= BADDATA;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEMARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wdcnt;
    logic       r_err;

    // Counter reads 0 in the first BUSY cycle, so BUSY lasts TIMEOUT cycles
    assign w_timeout = (r_state == BUSY) && !bus.memdone && (r_wdcnt == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdcnt <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == BUSY)
                r_wdcnt <= r_wdcnt + 8'd1;
            else
                r_wdcnt <= 8'd0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.wbdone    = w_done[REQ_WB];
    assign bus.ddone     = w_done[REQ_D];
    assign bus.idone     = w_done[REQ_I];
    assign bus.rdata     = r_rdata;
    assign bus.memen     = r_memen;
    assign bus.memadr    = r_memadr;
    assign bus.memwdata  = r_memwdata;
    assign bus.membyteen = r_membyteen;
    assign bus.memrwb    = r_memrwb;

endmodule
`default_nettype wire

// File: tb/tb_memarbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memarbiter
// Brief    : Directed, table-driven self-checking bench for memarbiter.
// Revision : 1.0
// ============================================================================
module tb_memarbiter;

`ifdef MEMARB_WATCHDOG_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        logic        swc;
        logic        wben;
        logic        den;
        logic        ien;
        logic [29:0] wbadr;
        logic [31:0] wbdata;
        logic [3:0]  wbbyteen;
        logic [29:0] dadr;
        logic [29:0] iadr;
        int          lat;
        logic [31:0] memrdata;
        logic [2:0]  exp_done;
        logic [29:0] exp_adr;
        logic        exp_rwb;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [2:0] dones;
    int         n_cmp;
    int         n_err;
    vec_t       vecs[8];

    memarbiter_if bus ();

    memarbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign dones = {bus.idone, bus.ddone, bus.wbdone};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        bus.wben = 1'b0;
        bus.den  = 1'b0;
        bus.ien  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.swc      = v.swc;
        bus.wbadr    = v.wbadr;
        bus.wbdata   = v.wbdata;
        bus.wbbyteen = v.wbbyteen;
        bus.dadr     = v.dadr;
        bus.iadr     = v.iadr;
        bus.wben     = v.wben;
        bus.den      = v.den;
        bus.ien      = v.ien;
        tick();
        chk("grant_memen", {31'd0, bus.memen}, 32'd1);
        chk("memadr", {2'd0, bus.memadr}, {2'd0, v.exp_adr});
        chk("memrwb", {31'd0, bus.memrwb}, {31'd0, v.exp_rwb});
        chk("membyteen", {28'd0, bus.membyteen}, {28'd0, v.exp_be});
        if (!v.exp_rwb)
            chk("memwdata", bus.memwdata, v.wbdata);
        for (int k = 0; k < v.lat; k++) begin
            chk("busy_nodone", {29'd0, dones}, 32'd0);
            tick();
        end
        chk("busy_memen", {31'd0, bus.memen}, 32'd1);
        bus.memrdata = v.memrdata;
        bus.memdone  = 1'b1;
        tick();
        bus.memdone  = 1'b0;
        chk("resp_memen", {31'd0, bus.memen}, 32'd0);
        chk("resp_done", {29'd0, dones}, {29'd0, v.exp_done});
        chk("resp_rdata", bus.rdata, v.exp_rdata);
        tick();
        chk("done_once", {29'd0, dones}, 32'd0);
        drop_all();
    endtask

    // All three request together; served order given as one-hot dones
    task automatic run_order(input logic swc, input logic [2:0] o0, input logic [2:0] o1,
                             input logic [2:0] o2);
        logic [2:0]  ord[3];
        logic [29:0] adr;
        ord[0] = o0; ord[1] = o1; ord[2] = o2;
        bus.swc   = swc;
        bus.wbadr = 30'h100; bus.dadr = 30'h200; bus.iadr = 30'h300;
        bus.wben  = 1'b1; bus.den = 1'b1; bus.ien = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            adr = ord[n][0] ? 30'h100 : (ord[n][1] ? 30'h200 : 30'h300);
            chk("order_memadr", {2'd0, bus.memadr}, {2'd0, adr});
            bus.memrdata = 32'h600D0000 + n;
            bus.memdone  = 1'b1;
            tick();
            bus.memdone  = 1'b0;
            chk("order_done", {29'd0, dones}, {29'd0, ord[n]});
            tick();
            if (ord[n][0]) bus.wben = 1'b0;
            if (ord[n][1]) bus.den  = 1'b0;
            if (ord[n][2]) bus.ien  = 1'b0;
        end
        tick();
        chk("order_idle_memen", {31'd0, bus.memen}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.swc = 1'b0; bus.wbadr = '0; bus.wbdata = '0; bus.wbbyteen = '0;
        bus.dadr = '0; bus.iadr = '0; bus.memrdata = '0; bus.memdone = 1'b0;
        drop_all();

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 32'h0, 4'h0, 30'h4AD, 30'h0, 1,
                    32'h21212121, 3'b010, 30'h4AD, 1'b1, 4'hF, 32'h21212121};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'h0AD, 32'hBEADBEEF, 4'b0011, 30'h0, 30'h0, 0,
                    32'h55555555, 3'b001, 30'h0AD, 1'b0, 4'b0011, 32'h21212121};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 32'h0, 4'h0, 30'h0, 30'h1234, 2,
                    32'hA5A5A5A5, 3'b100, 30'h1234, 1'b1, 4'hF, 32'hA5A5A5A5};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 30'h0, 32'h0, 4'h0, 30'h111, 30'h222, 0,
                    32'h00001111, 3'b010, 30'h111, 1'b1, 4'hF, 32'h00001111};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 30'h0, 32'h0, 4'h0, 30'h111, 30'h222, 0,
                    32'h00002222, 3'b100, 30'h222, 1'b1, 4'hF, 32'h00002222};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 30'h333, 32'hCAFEF00D, 4'b1100, 30'h111, 30'h222, 1,
                    32'h99999999, 3'b001, 30'h333, 1'b0, 4'b1100, 32'h00002222};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 30'h3FF, 32'h01234567, 4'b0110, 30'h111, 30'h222, 0,
                    32'h88888888, 3'b001, 30'h3FF, 1'b0, 4'b0110, 32'h00002222};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 30'h0, 32'h0, 4'h0, 30'h0, 30'h3FFFFFFF, 3,
                    32'hFFFFFFFF, 3'b100, 30'h3FFFFFFF, 1'b1, 4'hF, 32'hFFFFFFFF};

        // Reset values while reset is held low
        #12;
        chk("rst_memen", {31'd0, bus.memen}, 32'd0);
        chk("rst_dones", {29'd0, dones}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_memadr", {2'd0, bus.memadr}, 32'd0);
        chk("rst_memwdata", bus.memwdata, 32'd0);
        chk("rst_membyteen", {28'd0, bus.membyteen}, 32'd0);
        chk("rst_memrwb", {31'd0, bus.memrwb}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i]);

        // memdone while idle must change nothing
        bus.memrdata = 32'h12345678;
        bus.memdone  = 1'b1;
        tick();
        bus.memdone  = 1'b0;
        chk("idle_memdone_memen", {31'd0, bus.memen}, 32'd0);
        chk("idle_memdone_dones", {29'd0, dones}, 32'd0);
        chk("idle_memdone_rdata", bus.rdata, 32'hFFFFFFFF);
        tick();

        // ien withdrawn mid-transaction; den arriving in BUSY must wait
        bus.swc = 1'b0; bus.iadr = 30'h2A; bus.dadr = 30'h3B;
        bus.ien = 1'b1;
        tick();
        chk("drop_memadr", {2'd0, bus.memadr}, 32'h2A);
        bus.ien = 1'b0;
        bus.den = 1'b1;
        tick();
        tick();
        chk("drop_memen_held", {31'd0, bus.memen}, 32'd1);
        chk("late_req_waits", {2'd0, bus.memadr}, 32'h2A);
        bus.memrdata = 32'h0F0F0F0F;
        bus.memdone  = 1'b1;
        tick();
        bus.memdone  = 1'b0;
        chk("drop_idone", {29'd0, dones}, 32'b100);
        chk("drop_rdata", bus.rdata, 32'h0F0F0F0F);
        tick();
        chk("drop_done_once", {29'd0, dones}, 32'd0);
        tick();
        chk("late_req_granted", {2'd0, bus.memadr}, 32'h3B);
        bus.memrdata = 32'h3B3B3B3B;
        bus.memdone  = 1'b1;
        tick();
        bus.memdone  = 1'b0;
        chk("late_req_ddone", {29'd0, dones}, 32'b010);
        tick();
        bus.den = 1'b0;
        tick();

        run_order(1'b0, 3'b001, 3'b010, 3'b100);
        run_order(1'b1, 3'b001, 3'b100, 3'b010);

        // Reset pulled in the middle of BUSY
        bus.den = 1'b1; bus.dadr = 30'h0BEEF;
        tick();
        chk("pre_rst_memen", {31'd0, bus.memen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_memen", {31'd0, bus.memen}, 32'd0);
        chk("async_rst_dones", {29'd0, dones}, 32'd0);
        bus.den = 1'b0;
        bus.memdone = 1'b1;
        tick();
        bus.memdone = 1'b0;
        chk("in_rst_dones", {29'd0, dones}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_dones", {29'd0, dones}, 32'd0);
        chk("post_rst_memen", {31'd0, bus.memen}, 32'd0);
        run_vec(vecs[0]);

`ifdef MEMARB_WATCHDOG_EN
        bus.swc = 1'b0; bus.dadr = 30'h77; bus.den = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("wd_busy_memen", {31'd0, bus.memen}, 32'd1);
            tick();
        end
        chk("wd_last_busy_memen", {31'd0, bus.memen}, 32'd1);
        tick();
        chk("wd_memen", {31'd0, bus.memen}, 32'd0);
        chk("wd_ddone", {29'd0, dones}, 32'b010);
        chk("wd_rdata", bus.rdata, 32'hDEADBEEF);
        chk("wd_err", {31'd0, bus.err}, 32'd1);
        tick();
        bus.den = 1'b0;
        for (int k = 0; k < 4; k++)
            tick();
        chk("wd_err_sticky", {31'd0, bus.err}, 32'd1);
`else
        bus.swc = 1'b0; bus.dadr = 30'h77; bus.den = 1'b1;
        tick();
        for (int k = 0; k < 20; k++)
            tick();
        chk("nowd_memen_held", {31'd0, bus.memen}, 32'd1);
        chk("nowd_no_done", {29'd0, dones}, 32'd0);
        chk("nowd_err", {31'd0, bus.err}, 32'd0);
        bus.memrdata = 32'h77777777;
        bus.memdone  = 1'b1;
        tick();
        bus.memdone  = 1'b0;
        chk("nowd_ddone", {29'd0, dones}, 32'b010);
        tick();
        bus.den = 1'b0;
        tick();
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("final_rst_err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
